// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ write requesters.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   req/req_addr/req_data/req_last   per-requester transaction request, address, current byte, last flag
//   req_data_ack              combinational per-requester byte-consumed pulse
//   gnt, done, err            registered one-hot grant and completion/error pulses
//   m_start, m_abort          registered master start / forced-stop pulses
//   m_addr, m_data, m_last    combinational payload of the granted requester (0 when idle)
//   m_byte_ack, m_busy, m_done, m_nack   master status inputs
module i2c_bus_arbiter #(
   parameter int unsigned N_REQ      = 2,
   parameter int unsigned CLK_MHZ    = 50,
   parameter int unsigned TIMEOUT_US = 20000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_REQ-1:0]     req,
   input  logic [7*N_REQ-1:0]   req_addr,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_data_ack,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [N_REQ-1:0]     err,
   output logic                 m_start,
   output logic                 m_abort,
   output logic [6:0]           m_addr,
   output logic [7:0]           m_data,
   output logic                 m_last,
   input  logic                 m_byte_ack,
   input  logic                 m_busy,
   input  logic                 m_done,
   input  logic                 m_nack
);

   localparam int unsigned TO_CYC = CLK_MHZ * TIMEOUT_US;
   localparam int unsigned WD_W   = $clog2(TO_CYC + 1);
   localparam int unsigned PTR_W  = $clog2(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_GAP} state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [N_REQ-1:0]   err_q, err_d;
   logic               m_start_q, m_start_d;
   logic               m_abort_q, m_abort_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;

   logic               pick_vld_c;
   logic [PTR_W-1:0]   pick_idx_c;
   logic [PTR_W-1:0]   cand_c;
   logic               timeout_c;

   // Round-robin search from ptr+1; scanning downward lets the nearest candidate win last.
   always_comb begin
      pick_vld_c = 1'b0;
      pick_idx_c = '0;
      cand_c     = '0;
      for (int k = int'(N_REQ); k >= 1; k--) begin
         cand_c = PTR_W'((int'(ptr_q) + k) % int'(N_REQ));
         if (req[cand_c]) begin
            pick_vld_c = 1'b1;
            pick_idx_c = cand_c;
         end
      end
   end

   // Timeout fires on the last allowed XFER cycle so the abort lands TO_CYC cycles after m_start.
   assign timeout_c = (wdog_q >= WD_W'(TO_CYC - 1));

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_vld_c)           state_d = S_START;
         S_START: if (!m_busy)              state_d = S_XFER;
         S_XFER:  if (m_done || timeout_c)  state_d = S_GAP;
         S_GAP:                             state_d = S_IDLE;
         default:                           state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      wdog_d    = wdog_q;
      done_d    = '0;
      err_d     = '0;
      m_start_d = 1'b0;
      m_abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_vld_c) begin
               gnt_d = N_REQ'(1) << pick_idx_c;
               ptr_d = pick_idx_c;
            end
         end
         S_START: begin
            if (!m_busy) begin
               m_start_d = 1'b1;
               wdog_d    = '0;
            end
         end
         S_XFER: begin
            // m_done has priority over a coincident timeout
            if (m_done) begin
               done_d = gnt_q;
               err_d  = m_nack ? gnt_q : '0;
            end else if (timeout_c) begin
               m_abort_d = 1'b1;
               done_d    = gnt_q;
               err_d     = gnt_q;
            end
            if (wdog_q != WD_W'(TO_CYC)) wdog_d = wdog_q + WD_W'(1);
         end
         S_GAP:   gnt_d = '0;
         default: gnt_d = '0;
      endcase
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= '0;
         m_start_q <= 1'b0;
         m_abort_q <= 1'b0;
         ptr_q     <= PTR_W'(N_REQ - 1);
         wdog_q    <= '0;
      end else begin
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         m_start_q <= m_start_d;
         m_abort_q <= m_abort_d;
         ptr_q     <= ptr_d;
         wdog_q    <= wdog_d;
      end
   end

   // Payload mux from the one-hot grant; all zero when nothing is granted.
   always_comb begin
      m_addr = '0;
      m_data = '0;
      m_last = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (gnt_q[i]) begin
            m_addr = m_addr | req_addr[7*i +: 7];
            m_data = m_data | req_data[8*i +: 8];
            m_last = m_last | req_last[i];
         end
      end
   end

   assign req_data_ack = (state_q == S_XFER && m_byte_ack) ? gnt_q : '0;
   assign gnt          = gnt_q;
   assign done         = done_q;
   assign err          = err_q;
   assign m_start      = m_start_q;
   assign m_abort      = m_abort_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter: the bench plays both requesters and the I2C master,
// predicting grants with a round-robin model and timing from the documented latencies.
module tb_i2c_bus_arbiter;

   localparam int N  = 2;
   localparam int TO = 100;

   logic           CLK = 1'b0;
   logic           RST;
   logic [N-1:0]   req;
   logic [7*N-1:0] req_addr;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_data_ack;
   logic [N-1:0]   gnt, done, err;
   logic           m_start, m_abort, m_last;
   logic [6:0]     m_addr;
   logic [7:0]     m_data;
   logic           m_byte_ack, m_busy, m_done, m_nack;

   always #5 CLK = ~CLK;

   i2c_bus_arbiter #(.N_REQ(N), .CLK_MHZ(1), .TIMEOUT_US(TO)) dut (
      .CLK(CLK), .RST(RST), .req(req), .req_addr(req_addr), .req_data(req_data),
      .req_last(req_last), .req_data_ack(req_data_ack), .gnt(gnt), .done(done), .err(err),
      .m_start(m_start), .m_abort(m_abort), .m_addr(m_addr), .m_data(m_data), .m_last(m_last),
      .m_byte_ack(m_byte_ack), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack)
   );

   int         checks = 0;
   int         errors = 0;
   int         ptr_m;
   int         g_prev;
   int         g_now;
   logic [6:0] addr_m [N];
   logic [7:0] dat [N][8];
   int         bidx [N];
   int         blen [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Round-robin reference: first requesting index after the last grant, wrapping.
   function automatic int pick(input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (ptr_m + k) % N;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   task automatic present(input int i);
      if (bidx[i] < blen[i]) begin
         req_data[8*i +: 8] = dat[i][bidx[i]];
         req_last[i]        = (bidx[i] == blen[i] - 1);
      end
   endtask

   task automatic load(input int i, input int n, input logic [6:0] a);
      addr_m[i]          = a;
      req_addr[7*i +: 7] = a;
      blen[i]            = n;
      bidx[i]            = 0;
      for (int b = 0; b < 8; b++) dat[i][b] = 8'($urandom);
      present(i);
   endtask

   task automatic check_reset_outputs();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rda", 32'(req_data_ack), 0);
      chk("rst_m_start", 32'(m_start), 0);
      chk("rst_m_abort", 32'(m_abort), 0);
      chk("rst_m_addr", 32'(m_addr), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_last", 32'(m_last), 0);
   endtask

   // One full transaction, entered in a cycle where the DUT is idle and req is already driven.
   task automatic txn(input bit nack, input int busy_n, output int g);
      g     = pick(req);
      ptr_m = g;
      m_busy = (busy_n > 0);
      tick();
      chk("gnt", 32'(gnt), 32'(1 << g));
      chk("m_start_early", 32'(m_start), 0);
      for (int k = 0; k < busy_n; k++) begin
         tick();
         chk("m_start_busy", 32'(m_start), 0);
      end
      m_busy = 1'b0;
      tick();
      chk("m_start", 32'(m_start), 1);
      chk("m_addr", 32'(m_addr), 32'(addr_m[g]));
      if (!nack) begin
         for (int b = 0; b < blen[g]; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int w = 0; w < gap; w++) begin
               tick();
               chk("rda_idle", 32'(req_data_ack), 0);
            end
            m_byte_ack = 1'b1;
            #1;
            chk("m_data", 32'(m_data), 32'(dat[g][b]));
            chk("m_last", 32'(m_last), 32'(b == blen[g] - 1));
            chk("rda", 32'(req_data_ack), 32'(1 << g));
            tick();
            m_byte_ack = 1'b0;
            bidx[g]++;
            present(g);
         end
      end else begin
         for (int w = 0; w < 3; w++) begin
            tick();
            chk("rda_nack", 32'(req_data_ack), 0);
         end
      end
      tick();
      m_done = 1'b1;
      m_nack = nack;
      tick();
      m_done = 1'b0;
      m_nack = 1'b0;
      chk("done", 32'(done), 32'(1 << g));
      chk("err", 32'(err), nack ? 32'(1 << g) : 0);
      chk("no_abort", 32'(m_abort), 0);
      chk("gnt_gap", 32'(gnt), 32'(1 << g));
      tick();
      chk("gnt_clear", 32'(gnt), 0);
      chk("done_pulse", 32'(done), 0);
   endtask

   // Transaction where the master never finishes, or finishes exactly on the last allowed cycle.
   task automatic txn_to(input bit done_at_limit);
      int g;
      bit nk;
      g     = pick(req);
      ptr_m = g;
      nk    = 1'($urandom);
      m_busy = 1'b0;
      tick();
      chk("to_gnt", 32'(gnt), 32'(1 << g));
      tick();
      chk("to_m_start", 32'(m_start), 1);
      for (int k = 1; k < TO; k++) begin
         tick();
         chk("to_no_abort", 32'(m_abort), 0);
         chk("to_no_done", 32'(done), 0);
      end
      if (done_at_limit) begin
         m_done = 1'b1;
         m_nack = nk;
      end
      tick();
      m_done = 1'b0;
      m_nack = 1'b0;
      chk("to_abort", 32'(m_abort), done_at_limit ? 0 : 1);
      chk("to_done", 32'(done), 32'(1 << g));
      chk("to_err", 32'(err), (done_at_limit && !nk) ? 0 : 32'(1 << g));
      tick();
      chk("to_abort_pulse", 32'(m_abort), 0);
      chk("to_gnt_clear", 32'(gnt), 0);
   endtask

   initial begin
      RST = 1'b1;
      req = '0; req_addr = '0; req_data = '0; req_last = '0;
      m_byte_ack = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
      tick();
      tick();
      check_reset_outputs();
      RST   = 1'b0;
      ptr_m = N - 1;

      // Single requester, fixed payload
      load(0, 3, 7'h3C);
      dat[0][0] = 8'h00; dat[0][1] = 8'hAF; dat[0][2] = 8'h81;
      present(0);
      req = 2'b01;
      txn(1'b0, 0, g_now);
      req = 2'b00;
      tick();

      // Round robin with both requesters held; random payloads, nacks and busy delays
      req    = 2'b11;
      g_prev = -1;
      for (int t = 0; t < 4; t++) begin
         load(0, $urandom_range(1, 4), 7'($urandom));
         load(1, $urandom_range(1, 4), 7'($urandom));
         txn(1'($urandom), $urandom_range(0, 2), g_now);
         if (g_prev >= 0) chk("rr_alternate", 32'(g_now != g_prev), 1);
         g_prev = g_now;
      end
      req = 2'b00;
      tick();

      // Address NACK for requester 1
      load(1, 2, 7'($urandom));
      req = 2'b10;
      txn(1'b1, 0, g_now);
      req = 2'b00;
      tick();

      // Watchdog: no m_done at all, then m_done on the limit cycle
      load(0, 1, 7'($urandom));
      load(1, 1, 7'($urandom));
      req = 2'($urandom_range(1, 3));
      txn_to(1'b0);
      req = 2'b00;
      tick();
      req = 2'($urandom_range(1, 3));
      txn_to(1'b1);
      req = 2'b00;
      tick();

      // Busy master at grant, then reset mid-XFER
      load(0, 2, 7'($urandom));
      load(1, 2, 7'($urandom));
      req    = 2'b11;
      g_now  = pick(req);
      ptr_m  = g_now;
      m_busy = 1'b1;
      tick();
      chk("busy_gnt", 32'(gnt), 32'(1 << g_now));
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("busy_hold", 32'(m_start), 0);
      end
      m_busy = 1'b0;
      tick();
      chk("busy_release", 32'(m_start), 1);
      tick();
      tick();
      RST = 1'b1;
      tick();
      check_reset_outputs();
      RST   = 1'b0;
      ptr_m = N - 1;
      load(0, 2, 7'($urandom));
      load(1, 2, 7'($urandom));
      txn(1'b0, 0, g_now);
      req = 2'b00;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
